// File: rtl/instr_fetch_stage.sv
// MIPS fetch stage: PC, req/ready instruction-memory port, IF/ID register with
// a one-entry skid buffer for ID stalls and beq redirect with flush.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] id_instr,
  output logic [5:0]  id_opcode,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DROP} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx, pc_inc;
  logic [31:0] drop_addr, drop_addr_nx;
  ifid_t       ifid, ifid_nx, skid, skid_nx;
  logic        valid, valid_nx;

  assign pc_inc = pc + PC_STEP;

  // pc only moves on completion or redirect, so it doubles as the latched
  // request address while a fetch is outstanding; S_DROP keeps its own copy.
  assign imem_req  = (state == S_FETCH) || (state == S_DROP);
  assign imem_addr = (state == S_DROP) ? drop_addr : pc;

  assign id_instr  = ifid.instr;
  assign id_pc4    = ifid.pc4;
  assign id_opcode = ifid.instr[31:26];
  assign id_valid  = valid;

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    drop_addr_nx = drop_addr;
    ifid_nx      = ifid;
    skid_nx      = skid;
    valid_nx     = valid;
    case (state)
      S_IDLE: begin
        state_nx = S_FETCH;
        if (branch_taken) pc_nx = branch_target;
      end
      S_FETCH: begin
        if (branch_taken) begin
          pc_nx    = branch_target;
          valid_nx = 1'b0;
          skid_nx  = '0;
          if (!imem_ready) begin
            drop_addr_nx = pc;
            state_nx     = S_DROP;
          end
        end else if (imem_ready) begin
          pc_nx = pc_inc;
          if (id_stall) begin
            skid_nx  = '{instr: imem_rdata, pc4: pc_inc};
            state_nx = S_HOLD;
          end else begin
            ifid_nx  = '{instr: imem_rdata, pc4: pc_inc};
            valid_nx = 1'b1;
          end
        end else if (!id_stall) begin
          valid_nx = 1'b0;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_nx    = branch_target;
          valid_nx = 1'b0;
          skid_nx  = '0;
          state_nx = S_FETCH;
        end else if (!id_stall) begin
          ifid_nx  = skid;
          valid_nx = 1'b1;
          skid_nx  = '0;
          state_nx = S_FETCH;
        end
      end
      S_DROP: begin
        // The stale response is swallowed; redirects here only retarget pc.
        if (branch_taken) pc_nx = branch_target;
        if (imem_ready) state_nx = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      drop_addr <= '0;
      ifid      <= '0;
      skid      <= '0;
      valid     <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      drop_addr <= drop_addr_nx;
      ifid      <= ifid_nx;
      skid      <= skid_nx;
      valid     <= valid_nx;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed vector table, reset-in-hold sequence,
// then random traffic checked against a transaction-level reference model.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [31:0] id_pc4;
  logic        id_valid;

  int checks = 0;
  int errors = 0;

  instr_fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .id_instr(id_instr), .id_opcode(id_opcode), .id_pc4(id_pc4), .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        ready, stall, br;
    logic [31:0] tgt, rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr, exp_pc4;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, s, b, input logic [31:0] t, rd,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic ev, input logic [31:0] ei, ep);
    vec_t v;
    v.ready = r; v.stall = s; v.br = b; v.tgt = t; v.rdata = rd;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = ev;
    v.exp_instr = ei; v.exp_pc4 = ep;
    tbl.push_back(v);
  endfunction

  // Reference model: a fetcher that is either waiting out reset, fetching,
  // holding a stalled word in a queue, or draining an abandoned request.
  logic        m_boot;
  logic        m_draining;
  logic [31:0] m_stale_addr;
  logic [31:0] m_pc;
  logic [63:0] m_held[$];
  logic        m_valid;
  logic [31:0] m_instr, m_pc4;

  function automatic logic m_req();
    return !m_boot && (m_held.size() == 0);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_draining ? m_stale_addr : m_pc;
  endfunction

  task automatic m_reset();
    m_boot = 1'b1; m_draining = 1'b0; m_stale_addr = 0; m_pc = 0;
    m_held.delete(); m_valid = 1'b0; m_instr = 0; m_pc4 = 0;
  endtask

  task automatic m_step();
    logic [63:0] w;
    if (m_boot) begin
      m_boot = 1'b0;
      if (branch_taken) m_pc = branch_target;
    end else if (m_draining) begin
      if (branch_taken) m_pc = branch_target;
      if (imem_ready) m_draining = 1'b0;
    end else if (m_held.size() != 0) begin
      if (branch_taken) begin
        m_pc = branch_target; m_valid = 1'b0; m_held.delete();
      end else if (!id_stall) begin
        w = m_held.pop_front();
        m_instr = w[63:32]; m_pc4 = w[31:0]; m_valid = 1'b1;
      end
    end else if (branch_taken) begin
      if (!imem_ready) begin
        m_draining = 1'b1; m_stale_addr = m_pc;
      end
      m_pc = branch_target; m_valid = 1'b0;
    end else if (imem_ready) begin
      if (id_stall) m_held.push_back({imem_rdata, m_pc + 32'd4});
      else begin
        m_instr = imem_rdata; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!id_stall) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] word;
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 0;
    id_stall = 1'b0; branch_taken = 1'b0; branch_target = 0;

    // sequential, stall-on-miss, skid, redirect, drop, wrap, then stall into hold
    add(1,0,0,0,32'hDEAD, 0,0,           0,0,0);
    add(1,0,0,0,32'h0,    1,0,           1,32'h0,32'h4);
    add(1,0,0,0,32'h4,    1,32'h4,       1,32'h4,32'h8);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0, 1,32'h8, 0,0,0);
    add(1,0,0,0,32'h8,    1,32'h8,       1,32'h8,32'hC);
    add(1,1,0,0,32'hC,    1,32'hC,       1,32'h8,32'hC);
    add(0,1,0,0,0,        0,0,           1,32'h8,32'hC);
    add(1,1,0,0,32'hBAD,  0,0,           1,32'h8,32'hC);
    add(0,1,0,0,0,        0,0,           1,32'h8,32'hC);
    add(0,0,0,0,0,        0,0,           1,32'hC,32'h10);
    add(1,0,0,0,32'h10,   1,32'h10,      1,32'h10,32'h14);
    add(1,0,1,32'h40,32'h14, 1,32'h14,   0,0,0);
    add(1,0,0,0,32'h40,   1,32'h40,      1,32'h40,32'h44);
    add(1,0,1,32'h20,32'h44, 1,32'h44,   0,0,0);
    add(0,0,1,32'h80,0,   1,32'h20,      0,0,0);
    add(0,0,0,0,0,        1,32'h20,      0,0,0);
    add(0,0,0,0,0,        1,32'h20,      0,0,0);
    add(1,0,0,0,32'h20,   1,32'h20,      0,0,0);
    add(1,0,0,0,32'h80,   1,32'h80,      1,32'h80,32'h84);
    add(1,0,1,32'hFFFF_FFFC,32'h84, 1,32'h84, 0,0,0);
    add(1,0,0,0,32'hCAFE_0000, 1,32'hFFFF_FFFC, 1,32'hCAFE_0000,32'h0);
    add(1,0,0,0,32'h11,   1,32'h0,       1,32'h11,32'h4);
    add(1,1,0,0,32'h22,   1,32'h4,       1,32'h11,32'h4);
    add(0,1,0,0,0,        0,0,           1,32'h11,32'h4);

    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_instr", id_instr, 0);
    chk("rst_pc4", id_pc4, 0);
    chk("rst_opcode", id_opcode, 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      imem_ready = tbl[i].ready; id_stall = tbl[i].stall;
      branch_taken = tbl[i].br; branch_target = tbl[i].tgt; imem_rdata = tbl[i].rdata;
      chk($sformatf("v%0d_req", i), imem_req, tbl[i].exp_req);
      if (tbl[i].exp_req) chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].exp_addr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), id_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        chk($sformatf("v%0d_instr", i), id_instr, tbl[i].exp_instr);
        chk($sformatf("v%0d_pc4", i), id_pc4, tbl[i].exp_pc4);
        word = tbl[i].exp_instr;
        chk($sformatf("v%0d_opcode", i), id_opcode, word[31:26]);
      end
    end

    // reset asserted while a word sits in the skid: outputs clear without a clock
    #2 rst_n = 1'b0;
    #1;
    chk("hold_rst_valid", id_valid, 0);
    chk("hold_rst_instr", id_instr, 0);
    chk("hold_rst_pc4", id_pc4, 0);
    chk("hold_rst_req", imem_req, 0);
    @(negedge clk);
    rst_n = 1'b1; id_stall = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    chk("refetch_idle_req", imem_req, 0);
    @(negedge clk);
    chk("refetch_req", imem_req, 1);
    chk("refetch_addr", imem_addr, 0);
    @(posedge clk); #1;
    chk("refetch_valid", id_valid, 1);
    chk("refetch_instr", id_instr, 32'h1234_5678);
    chk("refetch_pc4", id_pc4, 32'h4);
    chk("refetch_opcode", id_opcode, 6'h04);

    // random traffic against the reference model
    @(negedge clk);
    rst_n = 1'b0; imem_ready = 1'b0; id_stall = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_req", imem_req, m_req());
      if (m_req()) chk("rnd_addr", imem_addr, m_addr());
      chk("rnd_valid", id_valid, m_valid);
      if (m_valid) begin
        chk("rnd_instr", id_instr, m_instr);
        chk("rnd_pc4", id_pc4, m_pc4);
        chk("rnd_opcode", id_opcode, m_instr[31:26]);
      end
      imem_ready   = ($urandom_range(0, 3) != 0);
      id_stall     = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 7))
        0:       branch_target = 32'hFFFF_FFF8;
        1:       branch_target = $urandom;
        default: branch_target = $urandom & 32'h0000_FFFC;
      endcase
      imem_rdata = $urandom;
      m_step();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
